circ_event_logger: RTL and testbench

- Downstream capture stage for the gate-level combinational test circuits.
- Samples the circuit's output bus once per clock and detects any change against the previous sample.
- Records each change as a {timestamp, value} event in a small FIFO; a consumer drains events over a valid/ready handshake.
- Gives the simulator flow a cycle-accurate trace of output transitions, including glitch-length pulses of one cycle or more.

---
 rtl/circ_event_logger.sv | 177 +++++++++++++++++
 tb/tb_circ_event_logger.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/circ_event_logger.sv
// circ_event_logger
//   Capture stage for a combinational circuit under test. Samples sig_in once
//   per clock and, while logging is running, records every change as a
//   {timestamp, value} event in a small first-word-fall-through FIFO.
//
//   State table
//     state | meaning
//     IDLE  | logging off, waiting for enable
//     ARM   | latch baseline sample, no event recorded
//     RUN   | compare each sample to the previous one, push on change
//
// Ports
//   clk       : single clock, all state updates on rising edge
//   rst       : synchronous active-high reset
//   enable    : logging enable
//   sig_in    : monitored outputs of the circuit under test
//   ev_valid  : FIFO head holds an event
//   ev_ready  : consumer accepts head event this cycle
//   ev_ts     : timestamp of head event (last popped value when empty)
//   ev_val    : sampled value of head event (last popped value when empty)
//   ev_count  : FIFO occupancy
//   overflow  : sticky, at least one event dropped
//   drops     : saturating dropped-event counter
//   clr_ovf   : clears overflow and drops
module circ_event_logger #(
    parameter int WIDTH      = 3,
    parameter int TS_WIDTH   = 16,
    parameter int DEPTH      = 8,
    parameter int DROP_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         sig_in,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [TS_WIDTH-1:0]      ev_ts,
    output logic [WIDTH-1:0]         ev_val,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     overflow,
    output logic [DROP_WIDTH-1:0]    drops,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = TS_WIDTH + WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [WIDTH-1:0]      prev_q, prev_d;
    logic [EW-1:0]         mem_q [DEPTH];
    logic [EW-1:0]         mem_d [DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [TS_WIDTH-1:0]   last_ts_q, last_ts_d;
    logic [WIDTH-1:0]      last_val_q, last_val_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0] drops_q, drops_d;

    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  wr_en;
    logic [EW-1:0]         head;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bit means full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        push    = 1'b0;
        ts_d    = ts_q + TS_WIDTH'(1);
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_ARM;
            end
            ST_ARM: begin
                prev_d  = sig_in;
                state_d = enable ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    push   = (sig_in != prev_q);
                    prev_d = sig_in;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        last_ts_d  = last_ts_q;
        last_val_d = last_val_q;
        overflow_d = overflow_q;
        drops_d    = drops_q;

        pop   = !empty && ev_ready;
        // A same-cycle pop frees a slot, so a full FIFO only drops without it.
        drop  = push && full && !pop;
        wr_en = push && !drop;

        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = {ts_q, sig_in};
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
            last_ts_d  = head[EW-1:WIDTH];
            last_val_d = head[WIDTH-1:0];
        end

        // A drop in the clearing cycle still counts as the first new drop.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf)        drops_d = DROP_WIDTH'(1);
            else if (!(&drops_q)) drops_d = drops_q + DROP_WIDTH'(1);
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
            drops_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ts_q       <= '0;
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_ts_q  <= '0;
            last_val_q <= '0;
            overflow_q <= 1'b0;
            drops_q    <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_ts_q  <= last_ts_d;
            last_val_q <= last_val_d;
            overflow_q <= overflow_d;
            drops_q    <= drops_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ev_valid = !empty;
    assign ev_ts    = empty ? last_ts_q  : head[EW-1:WIDTH];
    assign ev_val   = empty ? last_val_q : head[WIDTH-1:0];
    assign ev_count = wr_ptr_q - rd_ptr_q;
    assign overflow = overflow_q;
    assign drops    = drops_q;

endmodule

// File: tb/tb_circ_event_logger.sv
module tb_circ_event_logger;

    localparam int WIDTH = 3;
    localparam int TSW   = 16;
    localparam int DEPTH = 8;
    localparam int DW    = 8;

    typedef struct packed {
        logic [TSW-1:0]   ts;
        logic [WIDTH-1:0] val;
    } ev_t;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [WIDTH-1:0] sig_in;
    logic             ev_valid;
    logic             ev_ready;
    logic [TSW-1:0]   ev_ts;
    logic [WIDTH-1:0] ev_val;
    logic [3:0]       ev_count;
    logic             overflow;
    logic [DW-1:0]    drops;
    logic             clr_ovf;

    circ_event_logger #(
        .WIDTH(WIDTH), .TS_WIDTH(TSW), .DEPTH(DEPTH), .DROP_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ts(ev_ts),
        .ev_val(ev_val), .ev_count(ev_count), .overflow(overflow),
        .drops(drops), .clr_ovf(clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Events the stimulus expects the upcoming edge to capture.
    ev_t pend_q[$];
    // Reference model of the event FIFO contents.
    ev_t model_q[$];

    // Stimulus-side bookkeeping: consecutive enabled edges since reset or
    // disable, timestamp the next edge will see, and the last driven sample.
    int             streak  = 0;
    logic [TSW-1:0] ts_cnt  = '0;
    logic [WIDTH-1:0] prev_sig = '0;

    // Model state kept by the monitor.
    bit             started = 0;
    ev_t            last_ev;
    bit             m_ovf;
    int             m_drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus. Logging reaches RUN on the third consecutive
    // enabled edge; from then on any sample different from the previous
    // one is an event stamped with that edge's timestamp.
    task automatic cyc(input logic r, input logic e, input logic [WIDTH-1:0] s,
                       input logic rd, input logic c);
        ev_t x;
        rst = r; enable = e; sig_in = s; ev_ready = rd; clr_ovf = c;
        if (r) begin
            streak = 0;
            ts_cnt = '0;
        end else begin
            streak = e ? ((streak < 3) ? streak + 1 : 3) : 0;
            if (e && streak == 3 && s != prev_sig) begin
                x.ts  = ts_cnt;
                x.val = s;
                pend_q.push_back(x);
            end
            ts_cnt = ts_cnt + 1'b1;
        end
        prev_sig = s;
        @(posedge clk);
        #1;
    endtask

    // Monitor: inputs are stable at the falling edge, so compare the DUT's
    // current outputs against the model, then advance the model through the
    // upcoming rising edge.
    always @(negedge clk) begin
        ev_t   hd;
        bit    do_pop;
        bit    has_push;
        bit    do_drop;
        ev_t   np;
        if (started) begin
            hd = (model_q.size() > 0) ? model_q[0] : last_ev;
            chk("ev_count", 32'(ev_count), 32'(model_q.size()));
            chk("ev_valid", 32'(ev_valid), 32'(model_q.size() > 0));
            chk("ev_ts",    32'(ev_ts),    32'(hd.ts));
            chk("ev_val",   32'(ev_val),   32'(hd.val));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("drops",    32'(drops),    32'(m_drops));
        end
        if (rst) begin
            model_q.delete();
            pend_q.delete();
            last_ev = '0;
            m_ovf   = 0;
            m_drops = 0;
            started = 1;
        end else if (started) begin
            do_pop   = (model_q.size() > 0) && ev_ready;
            has_push = (pend_q.size() > 0);
            np       = has_push ? pend_q.pop_front() : '0;
            do_drop  = has_push && model_q.size() == DEPTH && !do_pop;
            if (do_pop) last_ev = model_q.pop_front();
            if (has_push && !do_drop) model_q.push_back(np);
            if (do_drop) begin
                m_ovf   = 1;
                m_drops = clr_ovf ? 1 : ((m_drops == 255) ? 255 : m_drops + 1);
            end else if (clr_ovf) begin
                m_ovf   = 0;
                m_drops = 0;
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] s;
        rst = 1; enable = 0; sig_in = '0; ev_ready = 0; clr_ovf = 0;
        cyc(1, 0, 3'b000, 0, 0);
        cyc(1, 0, 3'b000, 0, 0);

        // Basic capture: change sampled at ts=5, ARM baseline gives no event.
        for (int i = 0; i < 5; i++) cyc(0, 1, 3'b000, 1, 0);
        cyc(0, 1, 3'b101, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 3'b101, 1, 0);

        // Back-to-back changes held, then drained in order.
        cyc(0, 1, 3'b000, 0, 0);
        cyc(0, 1, 3'b001, 0, 0);
        cyc(0, 1, 3'b011, 0, 0);
        cyc(0, 1, 3'b111, 0, 0);
        cyc(0, 1, 3'b111, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 3'b111, 1, 0);

        // Overflow: ten changes into a stalled FIFO, then clear.
        s = 3'b111;
        for (int i = 0; i < 10; i++) begin
            s = s ^ 3'((i % 7) + 1);
            cyc(0, 1, s, 0, 0);
        end
        cyc(0, 1, s, 0, 1);
        cyc(0, 1, s, 0, 0);

        // Full with simultaneous push and pop, then a drop in the clear cycle.
        s = ~s;
        cyc(0, 1, s, 1, 0);
        s = ~s;
        cyc(0, 1, s, 0, 1);
        cyc(0, 1, s, 0, 0);

        // Drop counter saturation.
        for (int i = 0; i < 300; i++) begin
            s = s ^ 3'b010;
            cyc(0, 1, s, 0, 0);
        end
        cyc(0, 1, s, 0, 1);
        for (int i = 0; i < 9; i++) cyc(0, 1, s, 1, 0);

        // Enable gating: changes while disabled and on re-arm are ignored.
        cyc(0, 0, 3'b001, 1, 0);
        cyc(0, 0, 3'b100, 1, 0);
        cyc(0, 1, 3'b110, 1, 0);
        cyc(0, 1, 3'b110, 1, 0);
        cyc(0, 1, 3'b110, 1, 0);
        cyc(0, 1, 3'b010, 1, 0);
        cyc(0, 1, 3'b010, 1, 0);
        cyc(0, 1, 3'b010, 1, 0);

        // Reset mid-stream with events queued.
        for (int i = 0; i < 4; i++) cyc(0, 1, 3'(i + 3), 0, 0);
        cyc(1, 1, 3'b010, 0, 0);

        // Timestamp wrap: event sampled on the edge where ts returns to 0.
        for (int i = 0; i < 65536; i++) cyc(0, 1, 3'b000, 1, 0);
        cyc(0, 1, 3'b011, 0, 0);
        cyc(0, 1, 3'b011, 0, 0);
        cyc(0, 1, 3'b011, 1, 0);
        cyc(0, 1, 3'b011, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r, e, rd, c;
            r  = ($urandom_range(0, 499) == 0);
            e  = ($urandom_range(0, 9) != 0);
            rd = ($urandom_range(0, 2) == 0);
            c  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) s = 3'($urandom);
            cyc(r, e, s, rd, c);
        end
        for (int i = 0; i < 10; i++) cyc(0, 1, s, 1, 0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
